// File: rtl/cam_pkg.sv
// Shared constants and state encoding for the OV7670 capture path.
// Screen size, buffer widths, RGB332 reference colours and the FSM states.
package cam_pkg;
    localparam int CAM_SCREEN_X = 160;
    localparam int CAM_SCREEN_Y = 120;
    localparam int AW           = 15;
    localparam int DW           = 8;

    localparam logic [7:0] RED   = 8'hE0;
    localparam logic [7:0] GREEN = 8'h1C;
    localparam logic [7:0] BLUE  = 8'h03;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_LINE,
        BYTE_HI,
        BYTE_LO
    } cam_state_e;
endpackage

// File: rtl/cam_read.sv
// OV7670 RGB565 byte stream to RGB332 frame-buffer writer, one write per pixel.
// Build option CAM_READ_TEST_PATTERN_EN replaces camera data with a row/column pattern.
module cam_read #(
    parameter int CAM_SCREEN_X = cam_pkg::CAM_SCREEN_X,
    parameter int CAM_SCREEN_Y = cam_pkg::CAM_SCREEN_Y,
    parameter int AW           = cam_pkg::AW,
    parameter int DW           = cam_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          frame_done
);
    import cam_pkg::*;

    localparam logic [15:0]   X16 = 16'(CAM_SCREEN_X);
    localparam logic [15:0]   Y16 = 16'(CAM_SCREEN_Y);
    localparam logic [AW-1:0] XA  = AW'(CAM_SCREEN_X);

    cam_state_e    state_q, state_d;
    logic          vsync_q;
    logic [5:0]    hi_q, hi_d;
    logic [15:0]   col_q, col_d, row_q, row_d;
    logic [AW-1:0] base_q, base_d;
    logic          wr_q, wr_d, done_q, done_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [7:0]    pix;
    logic          in_win, line_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= WAIT_FRAME;
        else      state_q <= state_d;
    end

    // Capture starts on a vsync falling edge, so a frame already in flight at reset is skipped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FRAME: if (vsync_q && !vsync) state_d = WAIT_LINE;
            WAIT_LINE:  if (vsync) state_d = WAIT_FRAME;
                        else if (href) state_d = BYTE_LO;
            BYTE_LO:    if (vsync) state_d = WAIT_FRAME;
                        else if (href) state_d = BYTE_HI;
                        else state_d = WAIT_LINE;
            BYTE_HI:    if (vsync) state_d = WAIT_FRAME;
                        else if (href) state_d = BYTE_LO;
                        else state_d = WAIT_LINE;
            default:    state_d = WAIT_FRAME;
        endcase
    end

`ifdef CAM_READ_TEST_PATTERN_EN
    assign pix = {col_q[7:5], row_q[6:4], col_q[4:3]};
`else
    assign pix = {hi_q, px_data[4:3]};
`endif

    assign in_win = (col_q < X16) && (row_q < Y16);

    always_comb begin
        hi_d     = hi_q;
        col_d    = col_q;
        row_d    = row_q;
        base_d   = base_q;
        wr_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        line_end = 1'b0;
        case (state_q)
            WAIT_FRAME: if (vsync_q && !vsync) begin
                col_d  = '0;
                row_d  = '0;
                base_d = '0;
            end
            WAIT_LINE: if (vsync) done_d = 1'b1;
                       else if (href) hi_d = {px_data[7:5], px_data[2:0]};
            BYTE_LO: if (vsync) done_d = 1'b1;
                     else if (href) begin
                         // Out-of-window pixels leave column and address where they are.
                         if (in_win) begin
                             wr_d   = 1'b1;
                             addr_d = base_q + AW'(col_q);
                             data_d = DW'(pix);
                             col_d  = col_q + 16'd1;
                         end
                     end else line_end = 1'b1;
            BYTE_HI: if (vsync) done_d = 1'b1;
                     else if (href) hi_d = {px_data[7:5], px_data[2:0]};
                     else line_end = 1'b1;
            default: ;
        endcase
        if (line_end) begin
            col_d = '0;
            if (row_q < Y16) begin
                row_d  = row_q + 16'd1;
                base_d = base_q + XA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_q <= 1'b0;
            hi_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            hi_q    <= hi_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign px_wr       = wr_q;
    assign mem_px_addr = addr_q;
    assign mem_px_data = data_q;
    assign frame_done  = done_q;
endmodule
